ysyx_041514_clint_arb: RTL and testbench

YSYX_041514_CLINT_ARB -- requirements
Module: ysyx_041514_clint_arb

---
 rtl/ysyx_041514_clint_arb.sv | 151 +++++++++++++++
 tb/tb_ysyx_041514_clint_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_clint_arb.sv
// Two-master arbiter in front of the CLINT timer registers (mtime / mtimecmp).
// Define YSYX_041514_CLINT_DBG_PORT_EN to arbitrate the debug port m1; otherwise only m0 is served.
module ysyx_041514_clint_arb #(
    parameter int unsigned          ADDR_W        = 32,
    parameter int unsigned          XLEN          = 64,
    parameter logic [ADDR_W-1:0]    MTIME_ADDR    = 32'h0200_BFF8,
    parameter logic [ADDR_W-1:0]    MTIMECMP_ADDR = 32'h0200_4000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_resp_valid_o,
    input  logic              m0_resp_ready_i,
    output logic [XLEN-1:0]   m0_resp_data_o,
    output logic              m0_resp_err_o,

    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_resp_valid_o,
    input  logic              m1_resp_ready_i,
    output logic [XLEN-1:0]   m1_resp_data_o,
    output logic              m1_resp_err_o,

    output logic [ADDR_W-1:0] mtime_addr_o,
    output logic              mtime_write_valid_o,
    output logic [XLEN-1:0]   mtime_wdata_o,
    input  logic [XLEN-1:0]   mtime_rdata_i,
    input  logic              mtime_ge_mtime_i,
    output logic              mtip_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic              prio_q, prio_d;
    logic              mtip_q;

    logic m1_valid, m1_rready;
    logic gnt0, gnt1, hit, owner_rready;

`ifdef YSYX_041514_CLINT_DBG_PORT_EN
    assign m1_valid  = m1_req_valid_i;
    assign m1_rready = m1_resp_ready_i;
`else
    logic unused_m1;
    assign m1_valid  = 1'b0;
    assign m1_rready = 1'b0;
    assign unused_m1 = m1_req_valid_i ^ m1_resp_ready_i;
`endif

    assign hit          = (addr_q == MTIME_ADDR) || (addr_q == MTIMECMP_ADDR);
    assign owner_rready = id_q ? m1_rready : m0_resp_ready_i;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        prio_d  = prio_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // prio_q names the requester that wins a tie
                gnt0 = m0_req_valid_i && (!m1_valid || !prio_q);
                gnt1 = m1_valid && !gnt0;
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    we_d    = gnt1 ? m1_we_i : m0_we_i;
                    addr_d  = gnt1 ? m1_addr_i : m0_addr_i;
                    wdata_d = gnt1 ? m1_wdata_i : m0_wdata_i;
                    prio_d  = !gnt1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                data_d  = (hit && !we_q) ? mtime_rdata_i : '0;
                err_d   = !hit;
                state_d = StResp;
            end
            StResp: begin
                if (owner_rready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            mtip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
            mtip_q  <= mtime_ge_mtime_i;
        end
    end

    assign mtip_o              = mtip_q;
    assign mtime_addr_o        = (state_q == StAccess) ? addr_q : '0;
    assign mtime_wdata_o       = (state_q == StAccess) ? wdata_q : '0;
    assign mtime_write_valid_o = (state_q == StAccess) && we_q && hit && !rst;

    assign m0_req_ready_o  = gnt0 && !rst;
    assign m0_resp_valid_o = (state_q == StResp) && !id_q;
    assign m0_resp_data_o  = m0_resp_valid_o ? data_q : '0;
    assign m0_resp_err_o   = m0_resp_valid_o && err_q;

`ifdef YSYX_041514_CLINT_DBG_PORT_EN
    assign m1_req_ready_o  = gnt1 && !rst;
    assign m1_resp_valid_o = (state_q == StResp) && id_q;
    assign m1_resp_data_o  = m1_resp_valid_o ? data_q : '0;
    assign m1_resp_err_o   = m1_resp_valid_o && err_q;
`else
    assign m1_req_ready_o  = 1'b0;
    assign m1_resp_valid_o = 1'b0;
    assign m1_resp_data_o  = '0;
    assign m1_resp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_041514_clint_arb.sv
// Randomized transaction-level bench for ysyx_041514_clint_arb; honours YSYX_041514_CLINT_DBG_PORT_EN.
module tb_ysyx_041514_clint_arb;

    localparam logic [31:0] MtimeA    = 32'h0200_BFF8;
    localparam logic [31:0] MtimecmpA = 32'h0200_4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        m0_req_valid_i = 0, m0_we_i = 0, m0_resp_ready_i = 0;
    logic [31:0] m0_addr_i = 0;
    logic [63:0] m0_wdata_i = 0;
    logic        m1_req_valid_i = 0, m1_we_i = 0, m1_resp_ready_i = 0;
    logic [31:0] m1_addr_i = 0;
    logic [63:0] m1_wdata_i = 0;
    logic [63:0] mtime_rdata_i = 0;
    logic        mtime_ge_mtime_i = 0;
    logic        m0_req_ready_o, m0_resp_valid_o, m0_resp_err_o;
    logic        m1_req_ready_o, m1_resp_valid_o, m1_resp_err_o;
    logic [63:0] m0_resp_data_o, m1_resp_data_o, mtime_wdata_o;
    logic [31:0] mtime_addr_o;
    logic        mtime_write_valid_o, mtip_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: pending requests per master and the tie-break favourite
    bit          pend [2];
    bit          pwe  [2];
    logic [31:0] paddr[2];
    logic [63:0] pwd  [2];
    bit          pref;
    logic        ge_prev;

    ysyx_041514_clint_arb dut (
        .clk(clk), .rst(rst),
        .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_resp_valid_o(m0_resp_valid_o),
        .m0_resp_ready_i(m0_resp_ready_i), .m0_resp_data_o(m0_resp_data_o),
        .m0_resp_err_o(m0_resp_err_o),
        .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_resp_valid_o(m1_resp_valid_o),
        .m1_resp_ready_i(m1_resp_ready_i), .m1_resp_data_o(m1_resp_data_o),
        .m1_resp_err_o(m1_resp_err_o),
        .mtime_addr_o(mtime_addr_o), .mtime_write_valid_o(mtime_write_valid_o),
        .mtime_wdata_o(mtime_wdata_o), .mtime_rdata_i(mtime_rdata_i),
        .mtime_ge_mtime_i(mtime_ge_mtime_i), .mtip_o(mtip_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock; checks mtip tracks mtime_ge_mtime_i one cycle late, then re-randomizes it
    task automatic step();
        ge_prev = mtime_ge_mtime_i;
        @(posedge clk);
        @(negedge clk);
        if (!rst) check_eq("mtip", mtip_o, ge_prev);
        mtime_ge_mtime_i = 1'($urandom);
    endtask

    task automatic drive_reqs();
        m0_req_valid_i = pend[0]; m0_we_i = pwe[0]; m0_addr_i = paddr[0]; m0_wdata_i = pwd[0];
        m1_req_valid_i = pend[1]; m1_we_i = pwe[1]; m1_addr_i = paddr[1]; m1_wdata_i = pwd[1];
    endtask

    task automatic new_req(input int r);
        pend[r] = 1'b1;
        pwe[r]  = 1'($urandom);
        pwd[r]  = {$urandom, $urandom};
        case ($urandom_range(3))
            0:       paddr[r] = MtimeA;
            1:       paddr[r] = MtimecmpA;
            2:       paddr[r] = 32'h0200_0000;
            default: paddr[r] = $urandom;
        endcase
    endtask

    task automatic check_quiet_timer(input string tag);
        check_eq({tag, "_wv"}, mtime_write_valid_o, 1'b0);
        check_eq({tag, "_addr"}, mtime_addr_o, 32'h0);
    endtask

    initial begin
        int          g;
        int          hold;
        bit          hit;
        logic [63:0] rdata, exp_data;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; pwe[r] = 0; paddr[r] = 0; pwd[r] = 0;
        end
        pref = 0;

        // Reset state, with a request pending that must not be accepted
        m0_req_valid_i = 1'b1;
        @(negedge clk);
        check_eq("rst_ready0", m0_req_ready_o, 1'b0);
        check_eq("rst_resp0", {m0_resp_valid_o, m0_resp_err_o, m0_resp_data_o}, 66'h0);
        check_eq("rst_resp1", {m1_resp_valid_o, m1_resp_err_o, m1_resp_data_o}, 66'h0);
        check_eq("rst_mtip", mtip_o, 1'b0);
        check_quiet_timer("rst");
        m0_req_valid_i = 1'b0;
        rst = 1'b0;
        step();

`ifndef YSYX_041514_CLINT_DBG_PORT_EN
        // Debug port disabled: a held m1 request is ignored
        pend[1] = 1'b1; pwe[1] = 1'b1; paddr[1] = MtimecmpA; pwd[1] = 64'h55;
        drive_reqs();
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("m1_off_ready", m1_req_ready_o, 1'b0);
            check_eq("m1_off_wv", mtime_write_valid_o, 1'b0);
            check_eq("m1_off_resp", m1_resp_valid_o, 1'b0);
            step();
        end
        pend[1] = 1'b0;
        drive_reqs();
        // Directed m0 write of 0x64 to mtimecmp
        pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = MtimecmpA; pwd[0] = 64'h64;
`else
        // Both masters read mtime out of reset: m0 must win first, then m1
        pend[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = MtimeA; pwd[0] = 0;
        pend[1] = 1'b1; pwe[1] = 1'b0; paddr[1] = MtimeA; pwd[1] = 0;
`endif

        for (int n = 0; n < 80; n++) begin
            if (!pend[0] && $urandom_range(3) != 0) new_req(0);
`ifdef YSYX_041514_CLINT_DBG_PORT_EN
            if (!pend[1] && $urandom_range(3) != 0) new_req(1);
`endif
            drive_reqs();
            if (!pend[0] && !pend[1]) begin
                step();
                continue;
            end
            #1;
            g = (pend[0] && pend[1]) ? int'(pref) : (pend[0] ? 0 : 1);
            check_eq("grant0", m0_req_ready_o, g == 0);
            check_eq("grant1", m1_req_ready_o, g == 1);
            rdata = {$urandom, $urandom};
            mtime_rdata_i = rdata;
            hit = (paddr[g] == MtimeA) || (paddr[g] == MtimecmpA);
            exp_data = (hit && !pwe[g]) ? rdata : 64'h0;
            pend[g] = 1'b0;
            pref = (g == 0);
            step();

            // Access cycle; the loser keeps requesting and must not be accepted
            drive_reqs();
            #1;
            check_eq("acc_wv", mtime_write_valid_o, pwe[g] && hit);
            check_eq("acc_addr", mtime_addr_o, paddr[g]);
            check_eq("acc_wdata", mtime_wdata_o, pwd[g]);
            check_eq("acc_ready", {m0_req_ready_o, m1_req_ready_o}, 2'b00);
            check_eq("acc_resp", {m0_resp_valid_o, m1_resp_valid_o}, 2'b00);
            hold = $urandom_range(0, 5);
            step();

            for (int h = 0; h <= hold; h++) begin
                mtime_rdata_i = {$urandom, $urandom};
                #1;
                check_eq("resp_v0", m0_resp_valid_o, g == 0);
                check_eq("resp_v1", m1_resp_valid_o, g == 1);
                check_eq("resp_data", g ? m1_resp_data_o : m0_resp_data_o, exp_data);
                check_eq("resp_err", g ? m1_resp_err_o : m0_resp_err_o, !hit);
                check_eq("resp_ready", {m0_req_ready_o, m1_req_ready_o}, 2'b00);
                check_quiet_timer("resp");
                if (h == hold) begin
                    if (g == 0) m0_resp_ready_i = 1'b1;
                    else        m1_resp_ready_i = 1'b1;
                end
                step();
            end
            m0_resp_ready_i = 1'b0;
            m1_resp_ready_i = 1'b0;
        end

        // Reset during ACCESS aborts the write and suppresses its response
        pend[1] = 1'b0;
        pend[0] = 1'b1; pwe[0] = 1'b1; paddr[0] = MtimeA; pwd[0] = 64'hABCD;
        drive_reqs();
        #1;
        check_eq("abort_grant", m0_req_ready_o, 1'b1);
        step();
        pend[0] = 1'b0;
        drive_reqs();
        m0_resp_ready_i = 1'b1;
        #1;
        check_eq("abort_pre_wv", mtime_write_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        check_quiet_timer("abort");
        check_eq("abort_wdata", mtime_wdata_o, 64'h0);
        check_eq("abort_resp", {m0_resp_valid_o, m1_resp_valid_o}, 2'b00);
        check_eq("abort_mtip", mtip_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_abort_resp", m0_resp_valid_o, 1'b0);
            check_eq("post_abort_wv", mtime_write_valid_o, 1'b0);
        end
        m0_resp_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
